freq_chan_prog: RTL and testbench
=================================

# freq_chan_prog

Parametrised radio channel programmer: replaces the fixed 32-entry frequency lookup with an arithmetic frequency word (`BASE + ch*STEP`), and adds a channel state register and an optional hop sequencer. Each channel change is issued as two 8-bit register writes over a valid/ready port to the radio register-write (SPI) master. The packed legacy 32-bit word is kept for existing consumers.

## Interface
Parameters:
- `NCH`, 32, number of channels; must be ≥ 2.
- `CH_W`, 5, channel index width; must satisfy `2**CH_W >= NCH`.
- `BASE`, 16'h3C00, frequency word for channel 0.
- `STEP`, 16'h0030, frequency word increment per channel.
- `LO_ADDR`, 8'h0C, radio register that receives `word[7:0]`.
- `HI_ADDR`, 8'h0D, radio register that receives `word[15:8]`.
- `HOP_STRIDE`, 5, channel advance per hop; must satisfy 1 ≤ `HOP_STRIDE` < `NCH`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `ch_load` in 1: single-cycle pulse; load `ch_in` as the new channel.
- `ch_in` in CH_W: requested channel.
- `hop_req` in 1: single-cycle pulse; advance the channel by `HOP_STRIDE`. Only effective with `FREQ_HOP_EN`.
- `wr_valid` out 1: register write available.
- `wr_ready` in 1: consumer accepts the write.
- `wr_addr` out 8: register address.
- `wr_data` out 8: register data.
- `cur_ch` out CH_W: current channel.
- `freq_word` out 16: current frequency word.
- `freq_data` out 32: packed word `{LO_ADDR, freq_word[7:0], HI_ADDR, freq_word[15:8]}`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → CALC → WR_LO → WR_HI → IDLE.
- **IDLE, `ch_load`:** `cur_ch` ← `min(ch_in, NCH-1)` (saturate); go to CALC.
- **IDLE, `hop_req` (macro on):** `cur_ch` ← `cur_ch + HOP_STRIDE`; if the sum is ≥ `NCH`, subtract `NCH`. Go to CALC.
- **IDLE, `ch_load` and `hop_req` in the same cycle:** `ch_load` wins; the hop is dropped.
- **Requests in any non-IDLE state:** ignored and not queued. Masters must check `busy`.
- **CALC:**
  - `freq_word` ← `BASE + cur_ch*STEP`. Computed at 16+CH_W bits, then truncated to 16 bits (wraps silently).
  - `freq_data` is updated in the same cycle.
  - Go to WR_LO.
- **WR_LO:** `wr_valid`=1, `wr_addr`=`LO_ADDR`, `wr_data`=`freq_word[7:0]`. Advance to WR_HI on `wr_valid && wr_ready`.
- **WR_HI:** `wr_valid`=1, `wr_addr`=`HI_ADDR`, `wr_data`=`freq_word[15:8]`. Advance to IDLE on handshake.
- **Backpressure:** `wr_addr` and `wr_data` hold stable while `wr_valid && !wr_ready`. Once `wr_valid` is asserted, it is never withdrawn except by `rst`.
- **Reset values:**
  - State = IDLE; `cur_ch` = 0.
  - `freq_word` = `BASE`; `freq_data` = packed `BASE`.
  - `wr_valid` = 0; `busy` = 0; `wr_addr`/`wr_data` = 0.
  - Reset does not itself trigger a write.
- **`rst` mid-transfer:** the transfer is abandoned; `wr_valid` is 0 in the cycle after `rst` is sampled. The partial write is not replayed.

## Timing
- Request sampled at edge t → CALC during cycle t+1.
- `freq_word`, `freq_data` and `wr_valid` are first visible at cycle t+2.
- Minimum request-to-IDLE time is 4 cycles (with `wr_ready` held high).
- All outputs are registered; there is no combinational path from inputs to outputs.
- The `ch_in*STEP` multiply lies in the CALC stage only. It must close timing at the system clock for `CH_W` ≤ 8.

## Configuration
- `FREQ_HOP_EN` defined:
  - `hop_req` is honoured; hop logic and the wrap-subtract are compiled in.
- `FREQ_HOP_EN` undefined:
  - `hop_req` is ignored (port retained, unused).
  - Only `ch_load` changes the channel.
  - `HOP_STRIDE` is unchecked.

## Structure
- The shared package `freq_pkg` holds:
  - the FSM state enum;
  - `FREQ_W` = 16 and `REG_W` = 8;
  - the `pack_freq(lo_addr, hi_addr, word)` function used for `freq_data`.
- Sub-module `freq_word_calc`:
  - registered `BASE + ch*STEP` with a load enable;
  - reusable by the receive-side tuner.
- The FSM, channel register and hop logic live in the top level.

## Test plan
All scenarios use default parameters.
- **Load:** `ch_load` with `ch_in`=6 → `freq_word`=16'h3D20, `freq_data`=32'h0C200D3D, writes (0C,20) then (0D,3D), `busy` low 4 cycles after the pulse.
- **Top channel:** `ch_in`=31 → `freq_word`=16'h41D0, writes (0C,D0),(0D,41). `ch_in`=0 → (0C,00),(0D,3C).
- **Backpressure:** `wr_ready` low for 3 cycles in WR_LO → `wr_addr`=0C and `wr_data` stable throughout, then exactly 2 handshakes total.
- **Hop wrap (macro on):** with `cur_ch`=30, `hop_req` → `cur_ch`=3, `freq_word`=16'h3C90. With the macro off, the same stimulus leaves `cur_ch`=30 and `wr_valid` stays 0.
- **Collision/ignore:** `ch_load`(`ch_in`=2) and `hop_req` in the same cycle → `cur_ch`=2. A second `ch_load` issued while `busy` → ignored; only 2 writes occur.
- **Reset mid-WR_HI:** `rst` pulse during WR_HI → `wr_valid`=0 the next cycle, `cur_ch`=0, `freq_data`=32'h0C000D3C, no further writes.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared definitions for the channel programmer and the receive-side tuner.
package freq_pkg;

  localparam int unsigned FREQ_W = 16;
  localparam int unsigned REG_W  = 8;

  // Channel-change sequence: compute the word, then write its two bytes.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StWrLo,
    StWrHi
  } state_e;

  // Legacy packed layout: {lo_addr, word[7:0], hi_addr, word[15:8]}.
  function automatic logic [2*FREQ_W-1:0] pack_freq(input logic [REG_W-1:0]  lo_addr,
                                                    input logic [REG_W-1:0]  hi_addr,
                                                    input logic [FREQ_W-1:0] word);
    return {lo_addr, word[REG_W-1:0], hi_addr, word[FREQ_W-1:REG_W]};
  endfunction

endpackage

// File: rtl/freq_word_calc.sv
// Registered frequency word: word = BASE + ch*STEP, updated when load_i is high.
// The product is formed at FREQ_W+ChW bits and truncated, so large channels wrap.
module freq_word_calc
  import freq_pkg::*;
#(
  parameter int unsigned        ChW  = 5,
  parameter logic [FREQ_W-1:0]  Base = 16'h3C00,
  parameter logic [FREQ_W-1:0]  Step = 16'h0030
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ChW-1:0]    ch_i,
  output logic [FREQ_W-1:0] word_o
);

  localparam int unsigned ProdW = FREQ_W + ChW;

  logic [ProdW-1:0]  prod;
  logic [ProdW-1:0]  sum;
  logic [FREQ_W-1:0] word_q;

  // Full-width multiply-add; only the low FREQ_W bits are kept.
  always_comb begin
    prod = {{FREQ_W{1'b0}}, ch_i} * {{ChW{1'b0}}, Step};
    sum  = prod + {{ChW{1'b0}}, Base};
  end

  // Word register; reset value is the channel-0 word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= Base;
    end else if (load_i) begin
      word_q <= sum[FREQ_W-1:0];
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/freq_chan_prog.sv
// Radio channel programmer: channel register, optional hop sequencer and a
// two-write (low byte, then high byte) register-write handshake.
// Optional feature: define FREQ_HOP_EN to honour hop_req.
module freq_chan_prog
  import freq_pkg::*;
#(
  parameter int unsigned       NCH        = 32,
  parameter int unsigned       CH_W       = 5,
  parameter logic [FREQ_W-1:0] BASE       = 16'h3C00,
  parameter logic [FREQ_W-1:0] STEP       = 16'h0030,
  parameter logic [REG_W-1:0]  LO_ADDR    = 8'h0C,
  parameter logic [REG_W-1:0]  HI_ADDR    = 8'h0D,
  parameter int unsigned       HOP_STRIDE = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ch_load,
  input  logic [CH_W-1:0]     ch_in,
  input  logic                hop_req,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [REG_W-1:0]    wr_addr,
  output logic [REG_W-1:0]    wr_data,
  output logic [CH_W-1:0]     cur_ch,
  output logic [FREQ_W-1:0]   freq_word,
  output logic [2*FREQ_W-1:0] freq_data,
  output logic                busy
);

  if (NCH < 2) begin : gen_nch_chk
    $error("NCH must be at least 2");
  end
  if ((64'd1 << CH_W) < 64'(NCH)) begin : gen_chw_chk
    $error("CH_W too narrow for NCH");
  end

  localparam logic [CH_W-1:0] MaxCh = CH_W'(NCH - 1);

  state_e          state_q, state_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic [CH_W-1:0] load_ch;
  logic [CH_W-1:0] hop_ch;

  // Requested channel saturated to the top channel.
  assign load_ch = (ch_in > MaxCh) ? MaxCh : ch_in;

`ifdef FREQ_HOP_EN
  if (HOP_STRIDE < 1 || HOP_STRIDE >= NCH) begin : gen_stride_chk
    $error("HOP_STRIDE must be in [1, NCH)");
  end

  localparam logic [CH_W:0] Stride = (CH_W + 1)'(HOP_STRIDE);
  localparam logic [CH_W:0] NchW   = (CH_W + 1)'(NCH);

  logic [CH_W:0] hop_sum;
  logic [CH_W:0] hop_wrap;

  // Modular advance; one conditional subtract suffices since stride < NCH.
  always_comb begin
    hop_sum  = {1'b0, cur_ch_q} + Stride;
    hop_wrap = (hop_sum >= NchW) ? (hop_sum - NchW) : hop_sum;
    hop_ch   = hop_wrap[CH_W-1:0];
  end
`else
  logic unused_hop;
  assign unused_hop = hop_req ^ (HOP_STRIDE == 0);
  assign hop_ch     = cur_ch_q;
`endif

  // Next state and channel; requests outside IDLE are dropped, load beats hop.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    unique case (state_q)
      StIdle: begin
        if (ch_load) begin
          cur_ch_d = load_ch;
          state_d  = StCalc;
        end
`ifdef FREQ_HOP_EN
        else if (hop_req) begin
          cur_ch_d = hop_ch;
          state_d  = StCalc;
        end
`endif
      end
      StCalc: state_d = StWrLo;
      StWrLo: if (wr_ready) state_d = StWrHi;
      StWrHi: if (wr_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cur_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
    end
  end

  freq_word_calc #(
    .ChW  (CH_W),
    .Base (BASE),
    .Step (STEP)
  ) u_calc (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (state_q == StCalc),
    .ch_i   (cur_ch_q),
    .word_o (freq_word)
  );

  // Write port decoded from registered state and word only, so address and
  // data are inherently stable while the consumer stalls.
  always_comb begin
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    unique case (state_q)
      StWrLo: begin
        wr_valid = 1'b1;
        wr_addr  = LO_ADDR;
        wr_data  = freq_word[REG_W-1:0];
      end
      StWrHi: begin
        wr_valid = 1'b1;
        wr_addr  = HI_ADDR;
        wr_data  = freq_word[FREQ_W-1:REG_W];
      end
      default: ;
    endcase
  end

  assign cur_ch    = cur_ch_q;
  assign busy      = (state_q != StIdle);
  assign freq_data = pack_freq(LO_ADDR, HI_ADDR, freq_word);

endmodule

// File: tb/tb_freq_chan_prog.sv
// Self-checking bench for freq_chan_prog with default parameters. Expected
// register writes go into a scoreboard queue when a request is issued and are
// compared as handshakes occur.
module tb_freq_chan_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        ch_load;
  logic [4:0]  ch_in;
  logic        hop_req;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cur_ch;
  logic [15:0] freq_word;
  logic [31:0] freq_data;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;
  int hs_cnt  = 0;

  logic [15:0] sb_q[$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_val  = '0;

  freq_chan_prog dut (
    .clk       (clk),
    .rst       (rst),
    .ch_load   (ch_load),
    .ch_in     (ch_in),
    .hop_req   (hop_req),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cur_ch    (cur_ch),
    .freq_word (freq_word),
    .freq_data (freq_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int ch);
    logic [31:0] w;
    w = 32'h3C00 + ch * 32'h30;
    return w[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_writes(input int ch);
    logic [15:0] w;
    w = exp_word(ch);
    sb_q.push_back({8'h0C, w[7:0]});
    sb_q.push_back({8'h0D, w[15:8]});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Handshake monitor: scoreboard compare and backpressure stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("bp_valid_held", {31'd0, wr_valid}, 32'd1);
        check("bp_addr_data_hold", {16'd0, wr_addr, wr_data}, {16'd0, stall_val});
      end
      if (wr_valid && wr_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_write", {16'd0, wr_addr, wr_data}, 32'h0001_0000);
        end else begin
          check("write", {16'd0, wr_addr, wr_data}, {16'd0, sb_q.pop_front()});
        end
      end
      stall_prev <= wr_valid && !wr_ready;
      stall_val  <= {wr_addr, wr_data};
    end else begin
      stall_prev <= 1'b0;
    end
  end

  initial begin
    int hs0;
    rst      = 1'b1;
    ch_load  = 1'b0;
    ch_in    = '0;
    hop_req  = 1'b0;
    wr_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values.
    check("rst_cur_ch", {27'd0, cur_ch}, 32'd0);
    check("rst_freq_word", {16'd0, freq_word}, 32'h3C00);
    check("rst_freq_data", freq_data, 32'h0C000D3C);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_addr_data", {16'd0, wr_addr, wr_data}, 32'd0);
    tick();
    check("rst_no_write", {31'd0, wr_valid}, 32'd0);

    // Load channel 6 with exact cycle timing.
    hs0 = hs_cnt;
    ch_in = 5'd6; ch_load = 1'b1; push_writes(6);
    tick();
    ch_load = 1'b0;
    check("calc_busy", {31'd0, busy}, 32'd1);
    check("calc_no_valid", {31'd0, wr_valid}, 32'd0);
    tick();
    check("lo_valid", {31'd0, wr_valid}, 32'd1);
    check("ld6_word", {16'd0, freq_word}, 32'h3D20);
    check("ld6_data", freq_data, 32'h0C200D3D);
    tick();
    check("hi_busy", {31'd0, busy}, 32'd1);
    tick();
    check("ld6_idle_t4", {31'd0, busy}, 32'd0);
    check("ld6_hs", hs_cnt - hs0, 32'd2);

    // Top and bottom channels.
    ch_in = 5'd31; ch_load = 1'b1; push_writes(31);
    tick();
    ch_load = 1'b0;
    wait_idle();
    check("ld31_word", {16'd0, freq_word}, 32'h41D0);
    check("ld31_ch", {27'd0, cur_ch}, 32'd31);
    ch_in = 5'd0; ch_load = 1'b1; push_writes(0);
    tick();
    ch_load = 1'b0;
    wait_idle();
    check("ld0_word", {16'd0, freq_word}, 32'h3C00);

    // Backpressure: ready low for 3 cycles in WR_LO.
    hs0 = hs_cnt;
    wr_ready = 1'b0;
    ch_in = 5'd10; ch_load = 1'b1; push_writes(10);
    tick();
    ch_load = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_lo_addr", {24'd0, wr_addr}, 32'h0C);
      check("bp_lo_data", {24'd0, wr_data}, 32'hE0);
      tick();
    end
    wr_ready = 1'b1;
    wait_idle();
    check("bp_hs", hs_cnt - hs0, 32'd2);

    // Hop wrap from channel 30.
    ch_in = 5'd30; ch_load = 1'b1; push_writes(30);
    tick();
    ch_load = 1'b0;
    wait_idle();
    hs0 = hs_cnt;
    hop_req = 1'b1;
`ifdef FREQ_HOP_EN
    push_writes(3);
`endif
    tick();
    hop_req = 1'b0;
`ifdef FREQ_HOP_EN
    wait_idle();
    check("hop_ch", {27'd0, cur_ch}, 32'd3);
    check("hop_word", {16'd0, freq_word}, 32'h3C90);
    check("hop_hs", hs_cnt - hs0, 32'd2);
`else
    for (int i = 0; i < 4; i++) begin
      check("nohop_valid", {31'd0, wr_valid}, 32'd0);
      tick();
    end
    check("nohop_ch", {27'd0, cur_ch}, 32'd30);
`endif

    // Collision: load beats hop; a load while busy is ignored.
    hs0 = hs_cnt;
    ch_in = 5'd2; ch_load = 1'b1; hop_req = 1'b1; push_writes(2);
    tick();
    hop_req = 1'b0;
    ch_in = 5'd9;
    tick();
    ch_load = 1'b0;
    check("coll_ch_busy", {27'd0, cur_ch}, 32'd2);
    wait_idle();
    check("coll_ch", {27'd0, cur_ch}, 32'd2);
    check("coll_word", {16'd0, freq_word}, 32'h3C60);
    check("coll_hs", hs_cnt - hs0, 32'd2);

    // Reset during WR_HI.
    ch_in = 5'd7; ch_load = 1'b1; push_writes(7);
    tick();
    ch_load = 1'b0;
    tick();
    tick();
    check("pre_rst_hi_addr", {24'd0, wr_addr}, 32'h0D);
    hs0 = hs_cnt;
    rst = 1'b1; wr_ready = 1'b0;
    tick();
    rst = 1'b0; wr_ready = 1'b1;
    check("mid_rst_valid", {31'd0, wr_valid}, 32'd0);
    check("mid_rst_ch", {27'd0, cur_ch}, 32'd0);
    check("mid_rst_data", freq_data, 32'h0C000D3C);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    // The abandoned high-byte write is expected never to appear.
    check("abandoned_pending", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      check("post_rst_valid", {31'd0, wr_valid}, 32'd0);
      tick();
    end
    check("post_rst_hs", hs_cnt - hs0, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
